// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared constants for the Gray code decoder
package gray_pkg;

   localparam int GRAY_WIDTH_DEFAULT = 4;
   localparam int GRAY_ERRW_DEFAULT  = 8;

   localparam logic [1:0] DIR_NONE    = 2'b00;
   localparam logic [1:0] DIR_UP      = 2'b01;
   localparam logic [1:0] DIR_DOWN    = 2'b10;
   localparam logic [1:0] DIR_ILLEGAL = 2'b11;

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray to binary conversion
module gray_to_bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Running XOR from the MSB down; a scalar accumulator keeps the chain acyclic
   always_comb begin
      logic acc;
      bin = '0;
      acc = gray[WIDTH-1];
      bin[WIDTH-1] = acc;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         acc = acc ^ gray[i];
         bin[i] = acc;
      end
   end

endmodule

// File: rtl/gray_code_decoder.sv
// rtl/gray_code_decoder.sv - Gray decoder with step checker and error counter
module gray_code_decoder
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH_DEFAULT,
   parameter int ERRW  = GRAY_ERRW_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_gray,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_bin,
   output logic [1:0]       out_dir,
   output logic             out_step_err,
   output logic [ERRW-1:0]  err_count
);

   logic [WIDTH-1:0] prev_gray;
   logic             first_seen;
   logic [WIDTH-1:0] cur_bin;
   logic [WIDTH-1:0] prev_bin;
   logic [WIDTH-1:0] gray_diff;
   logic             accept;
   logic             one_bit_diff;
   logic             step_up;
   logic [1:0]       nxt_dir;
   logic             nxt_err;

   // Decode the incoming word and the last accepted word; the latter gives the
   // reference point for deciding whether the step went up or down.
   gray_to_bin #(.WIDTH(WIDTH)) u_dec_cur (
      .gray (in_gray),
      .bin  (cur_bin)
   );

   gray_to_bin #(.WIDTH(WIDTH)) u_dec_prev (
      .gray (prev_gray),
      .bin  (prev_bin)
   );

   // A single output register: space exists when it is empty or being drained
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Exactly one differing bit: non-zero and a power of two
   assign gray_diff    = in_gray ^ prev_gray;
   assign one_bit_diff = (gray_diff != '0) && ((gray_diff & (gray_diff - WIDTH'(1))) == '0);
   assign step_up      = (cur_bin == prev_bin + WIDTH'(1));

   // Classify the step of the incoming word relative to the previous accept
   always_comb begin
      nxt_dir = DIR_NONE;
      nxt_err = 1'b0;
      if (first_seen) begin
         if (one_bit_diff) begin
            nxt_dir = step_up ? DIR_UP : DIR_DOWN;
         end else begin
            nxt_dir = DIR_ILLEGAL;
            nxt_err = 1'b1;
         end
      end
   end

   // Output stage: load on accept, drop valid on a consume with nothing new
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_bin      <= '0;
         out_dir      <= DIR_NONE;
         out_step_err <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_bin      <= cur_bin;
         out_dir      <= nxt_dir;
         out_step_err <= nxt_err;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end

   // Checker history advances only on accepted words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_gray  <= '0;
         first_seen <= 1'b0;
      end else if (accept) begin
         prev_gray  <= in_gray;
         first_seen <= 1'b1;
      end
   end

   // Saturating count of accepted words flagged as step errors
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (accept && nxt_err && (err_count != '1)) begin
         err_count <= err_count + ERRW'(1);
      end
   end

endmodule

// File: tb/tb_gray_code_decoder.sv
// tb/tb_gray_code_decoder.sv - self-checking bench for gray_code_decoder
module tb_gray_code_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_gray = '0;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] out_bin;
   logic [1:0] out_dir;
   logic       out_step_err;
   logic [7:0] err_count;

   logic       in_valid2 = 1'b0;
   logic [3:0] in_gray2 = '0;
   logic       in_ready2;
   logic       out_valid2;
   logic       out_ready2 = 1'b1;
   logic [3:0] out_bin2;
   logic [1:0] out_dir2;
   logic       out_step_err2;
   logic [1:0] err_count2;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   gray_code_decoder #(.WIDTH(4), .ERRW(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_gray      (in_gray),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_bin      (out_bin),
      .out_dir      (out_dir),
      .out_step_err (out_step_err),
      .err_count    (err_count)
   );

   gray_code_decoder #(.WIDTH(4), .ERRW(2)) dut_sat (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid2),
      .in_gray      (in_gray2),
      .in_ready     (in_ready2),
      .out_valid    (out_valid2),
      .out_ready    (out_ready2),
      .out_bin      (out_bin2),
      .out_dir      (out_dir2),
      .out_step_err (out_step_err2),
      .err_count    (err_count2)
   );

   typedef struct packed {
      logic       rst;
      logic [3:0] g;
      logic [3:0] bin;
      logic [1:0] dir;
      logic       err;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [3:0] to_gray(input int n);
      logic [31:0] v;
      v = n ^ (n >> 1);
      return v[3:0];
   endfunction

   function automatic vec_t mk(input logic r, input logic [3:0] g, input logic [3:0] b,
                               input logic [1:0] d, input logic e, input logic [7:0] c);
      vec_t v;
      v.rst = r; v.g = g; v.bin = b; v.dir = d; v.err = e; v.cnt = c;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      in_valid2 = 1'b0;
      rst_n = 1'b0;
      #2;
      check("rst out_valid", 32'(out_valid), 0);
      check("rst out_bin", 32'(out_bin), 0);
      check("rst out_dir", 32'(out_dir), 0);
      check("rst out_step_err", 32'(out_step_err), 0);
      check("rst err_count", 32'(err_count), 0);
      check("rst in_ready", 32'(in_ready), 1);
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      // Forward sweep including the 15 -> 0 wrap
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(i == 0, to_gray(i), 4'(i), (i == 0) ? 2'b00 : 2'b01, 1'b0, 8'd0));
      vecs.push_back(mk(1'b0, 4'b0000, 4'd0, 2'b01, 1'b0, 8'd0));
      // Reverse sweep including the 0 -> 15 wrap
      for (int i = 15; i >= 0; i--)
         vecs.push_back(mk(i == 15, to_gray(i), 4'(i), (i == 15) ? 2'b00 : 2'b10, 1'b0, 8'd0));
      vecs.push_back(mk(1'b0, 4'b1000, 4'd15, 2'b10, 1'b0, 8'd0));
      // Two-bit jump then repeat
      vecs.push_back(mk(1'b1, 4'b0000, 4'd0, 2'b00, 1'b0, 8'd0));
      vecs.push_back(mk(1'b0, 4'b0011, 4'd2, 2'b11, 1'b1, 8'd1));
      vecs.push_back(mk(1'b0, 4'b0011, 4'd2, 2'b11, 1'b1, 8'd2));

      #1;
      do_reset();
      out_ready = 1'b1;
      foreach (vecs[k]) begin
         if (vecs[k].rst) do_reset();
         in_valid = 1'b1;
         in_gray  = vecs[k].g;
         step();
         check($sformatf("vec%0d out_valid", k), 32'(out_valid), 1);
         check($sformatf("vec%0d out_bin", k), 32'(out_bin), 32'(vecs[k].bin));
         check($sformatf("vec%0d out_dir", k), 32'(out_dir), 32'(vecs[k].dir));
         check($sformatf("vec%0d out_step_err", k), 32'(out_step_err), 32'(vecs[k].err));
         check($sformatf("vec%0d err_count", k), 32'(err_count), 32'(vecs[k].cnt));
      end
      in_valid = 1'b0;
      step();
      check("drain out_valid", 32'(out_valid), 0);

      // Stall for three cycles with a word waiting, then stream at full rate
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_gray = 4'b0000;
      step();
      out_ready = 1'b0;
      in_gray = 4'b0001;
      #1;
      check("stall in_ready", 32'(in_ready), 0);
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("stall%0d in_ready", c), 32'(in_ready), 0);
         check($sformatf("stall%0d out_valid", c), 32'(out_valid), 1);
         check($sformatf("stall%0d out_bin", c), 32'(out_bin), 0);
         check($sformatf("stall%0d out_dir", c), 32'(out_dir), 0);
      end
      out_ready = 1'b1;
      step();
      check("resume1 out_bin", 32'(out_bin), 1);
      check("resume1 out_dir", 32'(out_dir), 1);
      in_gray = 4'b0011;
      step();
      check("resume2 out_valid", 32'(out_valid), 1);
      check("resume2 out_bin", 32'(out_bin), 2);
      in_gray = 4'b0010;
      step();
      check("resume3 out_bin", 32'(out_bin), 3);
      check("resume3 out_dir", 32'(out_dir), 1);
      in_valid = 1'b0;
      step();
      check("resume idle out_valid", 32'(out_valid), 0);
      check("resume err_count", 32'(err_count), 0);

      // Reset while a result is stalled
      in_valid = 1'b1;
      in_gray = 4'b1111;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      check("prestall err_count", 32'(err_count), 1);
      check("prestall out_bin", 32'(out_bin), 10);
      step();
      check("prestall in_ready", 32'(in_ready), 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midstall rst out_valid", 32'(out_valid), 0);
      check("midstall rst err_count", 32'(err_count), 0);
      check("midstall rst out_bin", 32'(out_bin), 0);
      check("midstall rst in_ready", 32'(in_ready), 1);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_gray = 4'b0110;
      step();
      in_valid = 1'b0;
      check("post-rst out_valid", 32'(out_valid), 1);
      check("post-rst out_bin", 32'(out_bin), 4);
      check("post-rst out_dir", 32'(out_dir), 0);
      check("post-rst out_step_err", 32'(out_step_err), 0);
      check("post-rst err_count", 32'(err_count), 0);
      step();

      // Saturation with a 2-bit error counter
      do_reset();
      in_valid2 = 1'b1;
      in_gray2 = 4'b0000;
      step();
      check("sat first err_count", 32'(err_count2), 0);
      for (int j = 0; j < 5; j++) begin
         in_gray2 = (j % 2 == 0) ? 4'b0011 : 4'b0000;
         step();
         check($sformatf("sat%0d out_dir", j), 32'(out_dir2), 3);
         check($sformatf("sat%0d err_count", j), 32'(err_count2), (j < 3) ? j + 1 : 3);
      end
      in_valid2 = 1'b0;
      step();
      check("sat hold err_count", 32'(err_count2), 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gray_code_decoder.md
GRAY_CODE_DECODER -- requirements
Module: gray_code_decoder

Interface
REQ-001 Parameter WIDTH, default 4; width of Gray input and binary output, legal range 2..16.
REQ-002 Parameter ERRW, default 8; width of the step-error counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  in_gray holds a word to decode.
REQ-006 in_gray  input  WIDTH  Gray-coded word, MSB = bit WIDTH-1.
REQ-007 in_ready  output  1  decoder accepts a word this cycle.
REQ-008 out_valid  output  1  out_* fields hold a decoded result.
REQ-009 out_ready  input  1  downstream consumes the result this cycle.
REQ-010 out_bin  output  WIDTH  binary equivalent of the accepted Gray word.
REQ-011 out_dir  output  2  step direction versus the previous accepted word: 00 first/none, 01 up, 10 down, 11 illegal.
REQ-012 out_step_err  output  1  accepted word differs from the previous accepted word in 0 or 2+ bits.
REQ-013 err_count  output  ERRW  saturating count of words accepted with out_step_err set.

Function
REQ-014 Decode rule: bin[WIDTH-1] = gray[WIDTH-1]; bin[i] = bin[i+1] XOR gray[i] for i = WIDTH-2 down to 0.
REQ-015 Acceptance: a word is accepted on a cycle with in_valid && in_ready.
REQ-016 in_ready = !out_valid || out_ready (single output register stage, combinational ready, no bubble under continuous flow).
REQ-017 Latency: an accepted word appears on out_bin exactly one cycle after acceptance, with out_valid = 1.
REQ-018 out_valid/out_* hold stable while out_valid && !out_ready; they change only on a consume or a new accept.
REQ-019 Consume without a new accept clears out_valid next cycle; consume plus accept in the same cycle loads the new result with out_valid kept at 1.
REQ-020 The checker keeps prev_gray and a first_seen flag, updated only on accept.
REQ-021 First accept after reset: out_dir = 00, out_step_err = 0.
REQ-022 Later accepts: Hamming distance(in_gray, prev_gray) = 1 -> step legal; out_dir = 01 if new bin = prev bin + 1 mod 2^WIDTH, else 10.
REQ-023 Hamming distance 0 (repeat) or >= 2 -> out_dir = 11, out_step_err = 1.
REQ-024 Wrap-around is legal: the Gray word for 2^WIDTH-1 followed by 0 gives up; the reverse gives down.
REQ-025 err_count increments by 1 on each accept flagged as a step error, and saturates at 2^ERRW-1.
REQ-026 in_valid with in_ready = 0 changes no state (prev_gray, first_seen, err_count unaffected).

Reset
REQ-027 On rst_n low, asynchronously: out_valid = 0, out_bin = 0, out_dir = 00, out_step_err = 0, err_count = 0, prev_gray = 0, first_seen = 0.
REQ-028 Reset during a stalled output discards the pending result; the first accept after release is treated as first.
REQ-029 in_ready = 1 while reset is asserted and after release (it follows from out_valid = 0).

Structure
REQ-030 Shared package gray_pkg holds the DIR_NONE/DIR_UP/DIR_DOWN/DIR_ILLEGAL constants and the default WIDTH.
REQ-031 Combinational decoding sits in sub-module gray_to_bin (parameter WIDTH); the top module holds the handshake register, the checker and the counter.

Verification
REQ-032 WIDTH=4, stream Gray 0000,0001,0011,...,1000 then 0000 with out_ready = 1 -> out_bin = 0..15 then 0; out_dir = 00 first, then 01 throughout including the wrap; err_count = 0.
REQ-033 Send the same sequence reversed -> out_dir = 10 for each word after the first; wrap 0000->1000 gives out_bin = 15, dir 10.
REQ-034 Accept 0000 then 0011 -> out_bin = 2, out_dir = 11, out_step_err = 1, err_count = 1; then repeat 0011 -> out_dir = 11, err_count = 2.
REQ-035 Hold out_ready = 0 for 3 cycles with in_valid high -> in_ready = 0, out_* stable, no extra accept; on release, back-to-back accepts at 1 word per cycle.
REQ-036 ERRW=2, send 5 illegal steps -> err_count reaches 3 and holds at 3.
REQ-037 Assert rst_n low mid-stall, release, send 0110 -> out_bin = 4, out_dir = 00, out_step_err = 0, err_count = 0.
